// File: rtl/trees_acc_pkg.sv
// Shared constants and types for the trees_rtl_basic_dma64 accelerator:
// DMA encodings, datapath widths and the write-back FSM state type.
package trees_acc_pkg;

    localparam int PRED_WIDTH    = 32;
    localparam int BEAT_WIDTH    = 64;
    localparam int DMA_ADDR_W    = 32;
    localparam int DMA_LEN_W     = 32;
    localparam int DMA_SIZE_W    = 3;
    localparam int DMA_USER_W    = 6;

    localparam logic [DMA_SIZE_W-1:0] DMA_SIZE_64 = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/trees_pred_pair_packer.sv
// Packs two 32-bit predictions into one 64-bit beat behind a single-entry
// beat register, with the ready/valid handshaking on both sides.
module trees_pred_pair_packer
    import trees_acc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  has_samples,
    input  logic                  last_sample,
    input  logic                  pred_valid,
    output logic                  pred_ready,
    input  logic [PRED_WIDTH-1:0] pred_data,
    output logic                  chnl_valid,
    input  logic                  chnl_ready,
    output logic [BEAT_WIDTH-1:0] chnl_data
);

    logic                  odd_reg;
    logic [PRED_WIDTH-1:0] low_reg;
    logic [BEAT_WIDTH-1:0] beat_reg;
    logic                  beat_full_reg;

    logic completing_beat;
    logic accept;

    // A lone final prediction of an odd-length run also closes a beat.
    assign completing_beat = odd_reg || last_sample;
    assign pred_ready = en && has_samples &&
                        !(beat_full_reg && !chnl_ready && completing_beat);
    assign accept     = pred_valid && pred_ready;
    assign chnl_valid = beat_full_reg;
    assign chnl_data  = beat_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd_reg       <= 1'b0;
            low_reg       <= '0;
            beat_reg      <= '0;
            beat_full_reg <= 1'b0;
        end else if (clr) begin
            odd_reg       <= 1'b0;
            low_reg       <= '0;
            beat_reg      <= '0;
            beat_full_reg <= 1'b0;
        end else if (accept && completing_beat) begin
            // Refill wins over a same-cycle drain, so the register stays full.
            beat_reg      <= odd_reg ? {pred_data, low_reg}
                                     : {{PRED_WIDTH{1'b0}}, pred_data};
            beat_full_reg <= 1'b1;
            odd_reg       <= 1'b0;
        end else begin
            if (accept) begin
                low_reg <= pred_data;
                odd_reg <= 1'b1;
            end
            if (beat_full_reg && chnl_ready) begin
                beat_full_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trees_pred_writeback.sv
// Write-back stage: issues one DMA write per run and streams the packed
// prediction beats, then pulses done for the accelerator control.
module trees_pred_writeback
    import trees_acc_pkg::*;
#(
    parameter int MAX_BURST = 5000,
    parameter int DMA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           n_samples,
    input  logic [31:0]           base_index,
    input  logic                  pred_valid,
    output logic                  pred_ready,
    input  logic [PRED_WIDTH-1:0] pred_data,
    output logic                  dma_write_ctrl_valid,
    input  logic                  dma_write_ctrl_ready,
    output logic [DMA_ADDR_W-1:0] dma_write_ctrl_data_index,
    output logic [DMA_LEN_W-1:0]  dma_write_ctrl_data_length,
    output logic [DMA_SIZE_W-1:0] dma_write_ctrl_data_size,
    output logic [DMA_USER_W-1:0] dma_write_ctrl_data_user,
    output logic                  dma_write_chnl_valid,
    input  logic                  dma_write_chnl_ready,
    output logic [DMA_WIDTH-1:0]  dma_write_chnl_data,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    wb_state_t       state_reg;
    logic [CW-1:0]   samples_left_reg;
    logic [CW-1:0]   beats_left_reg;
    logic [CW-1:0]   length_reg;
    logic [31:0]     index_reg;
    logic            ctrl_valid_reg;
    logic            busy_reg;
    logic            done_reg;

    logic [CW-1:0]   n_eff;
    logic [CW-1:0]   len_calc;
    logic            pred_fire;
    logic            beat_fire;

    always_comb begin
        n_eff    = (n_samples > 32'(MAX_BURST)) ? CW'(MAX_BURST) : n_samples[CW-1:0];
        // ceil(n/2) without the n+1 carry that could overflow CW bits
        len_calc = (n_eff >> 1) + {{(CW-1){1'b0}}, n_eff[0]};
    end

    assign pred_fire = pred_valid && pred_ready;
    assign beat_fire = dma_write_chnl_valid && dma_write_chnl_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            samples_left_reg <= '0;
            beats_left_reg   <= '0;
            length_reg       <= '0;
            index_reg        <= '0;
            ctrl_valid_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (n_eff == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            samples_left_reg <= n_eff;
                            beats_left_reg   <= len_calc;
                            length_reg       <= len_calc;
                            index_reg        <= base_index;
                            ctrl_valid_reg   <= 1'b1;
                            state_reg        <= CTRL;
                        end
                    end
                end
                CTRL: begin
                    if (dma_write_ctrl_ready) begin
                        ctrl_valid_reg <= 1'b0;
                        state_reg      <= DATA;
                    end
                end
                DATA: begin
                    if (pred_fire && samples_left_reg != '0) begin
                        samples_left_reg <= samples_left_reg - ONE;
                    end
                    if (beat_fire && beats_left_reg != '0) begin
                        beats_left_reg <= beats_left_reg - ONE;
                        if (beats_left_reg == ONE) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    trees_pred_pair_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (state_reg == IDLE),
        .en          (state_reg == DATA),
        .has_samples (samples_left_reg != '0),
        .last_sample (samples_left_reg == ONE),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred_data   (pred_data),
        .chnl_valid  (dma_write_chnl_valid),
        .chnl_ready  (dma_write_chnl_ready),
        .chnl_data   (dma_write_chnl_data)
    );

    assign dma_write_ctrl_valid       = ctrl_valid_reg;
    assign dma_write_ctrl_data_index  = index_reg;
    assign dma_write_ctrl_data_length = {{(DMA_LEN_W-CW){1'b0}}, length_reg};
    assign dma_write_ctrl_data_size   = DMA_SIZE_64;
    assign dma_write_ctrl_data_user   = '0;
    assign busy                       = busy_reg;
    assign done                       = done_reg;

endmodule

// File: tb/tb_trees_pred_writeback.sv
// Scoreboard bench for trees_pred_writeback: the driver queues expected ctrl
// transactions, beats and done cycles; a negedge monitor pops and compares.
module tb_trees_pred_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n_samples = '0;
    logic [31:0] base_index = '0;
    logic        pred_valid = 1'b0;
    logic        pred_ready;
    logic [31:0] pred_data = '0;
    logic        ctrl_valid;
    logic        ctrl_ready = 1'b0;
    logic [31:0] ctrl_index;
    logic [31:0] ctrl_length;
    logic [2:0]  ctrl_size;
    logic [5:0]  ctrl_user;
    logic        chnl_valid;
    logic        chnl_ready = 1'b0;
    logic [63:0] chnl_data;
    logic        busy;
    logic        done;

    trees_pred_writeback #(.MAX_BURST(5000), .DMA_WIDTH(64)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .n_samples                  (n_samples),
        .base_index                 (base_index),
        .pred_valid                 (pred_valid),
        .pred_ready                 (pred_ready),
        .pred_data                  (pred_data),
        .dma_write_ctrl_valid       (ctrl_valid),
        .dma_write_ctrl_ready       (ctrl_ready),
        .dma_write_ctrl_data_index  (ctrl_index),
        .dma_write_ctrl_data_length (ctrl_length),
        .dma_write_ctrl_data_size   (ctrl_size),
        .dma_write_ctrl_data_user   (ctrl_user),
        .dma_write_chnl_valid       (chnl_valid),
        .dma_write_chnl_ready       (chnl_ready),
        .dma_write_chnl_data        (chnl_data),
        .busy                       (busy),
        .done                       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    logic [63:0] ctrl_q[$];   // {index, length}
    logic [63:0] beat_q[$];
    int          done_q[$];   // cycle at which done must be seen
    logic [31:0] pv[5000];

    function automatic void check(input string name, input bit ok,
                                  input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: every output presentation is compared with the queue front.
    always @(negedge clk) begin
        if (!rst) begin
            if (ctrl_valid) begin
                if (ctrl_q.size() == 0) begin
                    check("ctrl_unexpected", 1'b0, 64'(ctrl_valid), 64'd0);
                end else begin
                    check("ctrl_index", ctrl_index == ctrl_q[0][63:32], 64'(ctrl_index), 64'(ctrl_q[0][63:32]));
                    check("ctrl_length", ctrl_length == ctrl_q[0][31:0], 64'(ctrl_length), 64'(ctrl_q[0][31:0]));
                    check("ctrl_size", ctrl_size == 3'b011, 64'(ctrl_size), 64'd3);
                    check("ctrl_user", ctrl_user == 6'd0, 64'(ctrl_user), 64'd0);
                    if (ctrl_ready) begin
                        $display("ctrl  index=0x%0h length=%0d", ctrl_index, ctrl_length);
                        void'(ctrl_q.pop_front());
                    end
                end
            end
            if (chnl_valid) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 1'b0, chnl_data, 64'd0);
                end else begin
                    check("beat_data", chnl_data == beat_q[0], chnl_data, beat_q[0]);
                    if (chnl_ready) begin
                        void'(beat_q.pop_front());
                        if (beat_q.size() == 0) done_q.push_back(cyc + 1);
                    end
                end
            end
            if (done) begin
                if (done_q.size() != 0 && done_q[0] == cyc) begin
                    check("done_pulse", 1'b1, 64'd1, 64'd1);
                    $display("done  cycle=%0d", cyc);
                    void'(done_q.pop_front());
                end else begin
                    check("done_unexpected", 1'b0, 64'd1, 64'd0);
                end
            end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                check("done_missing", 1'b0, 64'd0, 64'd1);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pred_ready"}, pred_ready == 1'b0, 64'(pred_ready), 64'd0);
        check({tag, "_ctrl_valid"}, ctrl_valid == 1'b0, 64'(ctrl_valid), 64'd0);
        check({tag, "_ctrl_index"}, ctrl_index == 32'd0, 64'(ctrl_index), 64'd0);
        check({tag, "_ctrl_length"}, ctrl_length == 32'd0, 64'(ctrl_length), 64'd0);
        check({tag, "_ctrl_size"}, ctrl_size == 3'b011, 64'(ctrl_size), 64'd3);
        check({tag, "_ctrl_user"}, ctrl_user == 6'd0, 64'(ctrl_user), 64'd0);
        check({tag, "_chnl_valid"}, chnl_valid == 1'b0, 64'(chnl_valid), 64'd0);
        check({tag, "_chnl_data"}, chnl_data == 64'd0, chnl_data, 64'd0);
        check({tag, "_busy"}, busy == 1'b0, 64'(busy), 64'd0);
        check({tag, "_done"}, done == 1'b0, 64'(done), 64'd0);
    endtask

    // One complete run: expectations are queued, then preds fed from pv[].
    task automatic run(input int n, input logic [31:0] base, input bit stall,
                       input int ctrl_hold, input string tag);
        int  n_eff = (n > 5000) ? 5000 : n;
        int  len = (n_eff + 1) / 2;
        int  idx = 0;
        int  cnt = 0;
        bit  took = 1'b0;
        bit  seen_done = 1'b0;
        bit  hold_ok = 1'b1;
        if (n_eff > 0) ctrl_q.push_back({base, 32'(len)});
        for (int k = 0; k < len; k++)
            beat_q.push_back({(2 * k + 1 < n_eff) ? pv[2 * k + 1] : 32'd0, pv[2 * k]});
        @(posedge clk); #1;
        start = 1'b1; n_samples = 32'(n); base_index = base;
        ctrl_ready = (ctrl_hold == 0); chnl_ready = 1'b1; pred_valid = 1'b0;
        @(negedge clk);
        if (n_eff == 0) done_q.push_back(cyc + 1);
        while (!seen_done && cnt < 40000) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (took) idx++;
            ctrl_ready = (cnt >= ctrl_hold);
            if (idx < n_eff) begin
                pred_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pred_data  = pv[idx];
            end else begin
                // Keep offering junk past the end: none of it may be taken.
                pred_valid = (n_eff > 0);
                pred_data  = 32'hDEAD_0000 + 32'(idx);
            end
            chnl_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            took = pred_valid && pred_ready;
            if (cnt < ctrl_hold && pred_ready) hold_ok = 1'b0;
            if (done) begin
                seen_done = 1'b1;
                check({tag, "_busy_at_done"}, busy == 1'b1, 64'(busy), 64'd1);
            end
            cnt++;
        end
        check({tag, "_timeout"}, seen_done, 64'(seen_done), 64'd1);
        check({tag, "_pred_count"}, idx == n_eff, 64'(idx), 64'(n_eff));
        if (ctrl_hold > 0)
            check({tag, "_ready_low_in_ctrl"}, hold_ok, 64'(hold_ok), 64'd1);
        @(posedge clk); #1;
        pred_valid = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, busy == 1'b0, 64'(busy), 64'd0);
        check({tag, "_done_after"}, done == 1'b0, 64'(done), 64'd0);
        check({tag, "_ctrl_drained"}, ctrl_q.size() == 0, 64'(ctrl_q.size()), 64'd0);
        check({tag, "_beats_drained"}, beat_q.size() == 0, 64'(beat_q.size()), 64'd0);
        $display("run   %s n=%0d preds=%0d cycles=%0d", tag, n, idx, cnt);
    endtask

    initial begin
        int  idx;
        bit  took;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        pv[0] = 32'd1; pv[1] = 32'd2; pv[2] = 32'd3; pv[3] = 32'd4;
        run(4, 32'h100, 1'b0, 0, "n4");

        pv[0] = 32'd7; pv[1] = 32'd8; pv[2] = 32'd9;
        run(3, 32'h200, 1'b0, 0, "n3");

        run(0, 32'h300, 1'b0, 0, "n0");

        for (int i = 0; i < 5000; i++) pv[i] = 32'h5000_0000 | 32'(i);
        run(5000, 32'h1000, 1'b1, 0, "n5000");

        for (int i = 0; i < 6; i++) pv[i] = 32'hC0 + 32'(i);
        run(6, 32'h40, 1'b0, 20, "ctrlhold");

        // Abort mid-DATA with 3 of 6 preds taken and the beat register full.
        for (int i = 0; i < 6; i++) pv[i] = 32'hA0 + 32'(i);
        ctrl_q.push_back({32'h500, 32'd3});
        for (int k = 0; k < 3; k++) beat_q.push_back({pv[2 * k + 1], pv[2 * k]});
        @(posedge clk); #1;
        start = 1'b1; n_samples = 32'd6; base_index = 32'h500;
        ctrl_ready = 1'b1; chnl_ready = 1'b0; pred_valid = 1'b0;
        idx = 0; took = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (took) idx++;
            pred_valid = (idx < 6);
            pred_data  = (idx < 6) ? pv[idx] : 32'd0;
            @(negedge clk);
            took = pred_valid && pred_ready;
        end
        check("abort_accepted", idx == 3, 64'(idx), 64'd3);
        check("abort_beat_pending", chnl_valid == 1'b1, 64'(chnl_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        $display("abort preds=%0d", idx);
        ctrl_q.delete(); beat_q.delete(); done_q.delete();
        pred_valid = 1'b0; chnl_ready = 1'b0; ctrl_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        pv[0] = 32'h1111_0001; pv[1] = 32'h2222_0002;
        run(2, 32'h600, 1'b0, 0, "after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
